// File: rtl/downscale_pkg.sv
// Shared types and Q16.16 step helper for the streaming image downscaler.
package downscale_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EMIT,
    S_DONE
  } state_t;

  typedef enum logic {
    MODE_NEAREST,
    MODE_BOX
  } mode_t;

  // Source pixels advanced per destination pixel, Q16.16.
  function automatic logic [31:0] q16_step(input int src, input int dst);
    return 32'((longint'(src) <<< 16) / longint'(dst));
  endfunction

endpackage

// File: rtl/downscale_addr_gen.sv
// Destination raster counters, Q16.16 source coordinate accumulators and BRAM address
// generation with right/bottom edge clamping for the second box sample.
module downscale_addr_gen
  import downscale_pkg::*;
#(
  parameter int SRC_W  = 32,
  parameter int SRC_H  = 32,
  parameter int DST_W  = 16,
  parameter int DST_H  = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  input  logic [1:0]        rd_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              last_pixel
);

  localparam logic [31:0] STEP_X  = q16_step(SRC_W, DST_W);
  localparam logic [31:0] STEP_Y  = q16_step(SRC_H, DST_H);
  localparam logic [15:0] DX_LAST = 16'(DST_W - 1);
  localparam logic [15:0] DY_LAST = 16'(DST_H - 1);
  localparam logic [15:0] SX_LAST = 16'(SRC_W - 1);
  localparam logic [15:0] SY_LAST = 16'(SRC_H - 1);

  logic [15:0] dx_reg, dy_reg;
  logic [31:0] acc_x_reg, acc_y_reg;
  logic [15:0] sx, sy, sx1, sy1, rd_x, rd_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dx_reg    <= '0;
      dy_reg    <= '0;
      acc_x_reg <= '0;
      acc_y_reg <= '0;
    end else if (clear) begin
      dx_reg    <= '0;
      dy_reg    <= '0;
      acc_x_reg <= '0;
      acc_y_reg <= '0;
    end else if (advance) begin
      if (dx_reg == DX_LAST) begin
        dx_reg    <= '0;
        acc_x_reg <= '0;
        dy_reg    <= dy_reg + 16'd1;
        acc_y_reg <= acc_y_reg + STEP_Y;
      end else begin
        dx_reg    <= dx_reg + 16'd1;
        acc_x_reg <= acc_x_reg + STEP_X;
      end
    end
  end

  assign sx  = acc_x_reg[31:16];
  assign sy  = acc_y_reg[31:16];
  assign sx1 = (sx == SX_LAST) ? sx : sx + 16'd1;
  assign sy1 = (sy == SY_LAST) ? sy : sy + 16'd1;

  // Box read order: (sx,sy), (sx1,sy), (sx,sy1), (sx1,sy1).
  assign rd_x = rd_sel[0] ? sx1 : sx;
  assign rd_y = rd_sel[1] ? sy1 : sy;

  assign mem_addr   = ADDR_W'(32'(rd_y) * 32'(SRC_W) + 32'(rd_x));
  assign last_pixel = (dx_reg == DX_LAST) && (dy_reg == DY_LAST);

endmodule

// File: rtl/image_downscale_stream.sv
// Streams a downscaled image read from a sync-read BRAM port, nearest-neighbour or
// (when DOWNSCALE_BOX_EN is defined) 2x2 box average with round-half-up.
module image_downscale_stream
  import downscale_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int CH     = 1,
  parameter int SRC_W  = 32,
  parameter int SRC_H  = 32,
  parameter int DST_W  = 16,
  parameter int DST_H  = 16,
  parameter int ADDR_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_req,
  input  logic                mode,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [CH*PIX_W-1:0] mem_rd_dat,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH*PIX_W-1:0] out_data,
  output logic                out_last,
  output logic                busy,
  output logic                done
);

  localparam int DW = CH * PIX_W;

  if (DST_W == 0 || DST_W > SRC_W) begin : g_bad_dst_w
    $error("DST_W must be in 1..SRC_W");
  end
  if (DST_H == 0 || DST_H > SRC_H) begin : g_bad_dst_h
    $error("DST_H must be in 1..SRC_H");
  end
  if (longint'(SRC_W) * longint'(SRC_H) > (longint'(1) <<< ADDR_W)) begin : g_bad_addr
    $error("source image does not fit in ADDR_W");
  end

  state_t            state_reg;
  logic [1:0]        rd_sel;
  logic              last_rd;
  logic              addr_clear, addr_advance, last_pixel;
  logic [ADDR_W-1:0] rd_addr;
  logic [DW-1:0]     result;

`ifdef DOWNSCALE_BOX_EN
  mode_t      mode_reg;
  logic [1:0] rd_cnt_reg;
  logic       rd_pending_reg;
  logic       is_box;

  assign is_box  = (mode_reg == MODE_BOX);
  assign rd_sel  = rd_cnt_reg;
  assign last_rd = is_box ? (rd_cnt_reg == 2'd3) : 1'b1;

  // Data returns one cycle after the strobe; this marks which FETCH cycles carry a sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_pending_reg <= 1'b0;
    else        rd_pending_reg <= mem_rd_en;
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign rd_sel      = 2'd0;
  assign last_rd     = 1'b1;
`endif

  assign mem_rd_en    = (state_reg == S_FETCH);
  assign mem_addr     = mem_rd_en ? rd_addr : '0;
  assign addr_clear   = (state_reg == S_IDLE) && start_req;
  assign addr_advance = (state_reg == S_EMIT) && out_ready && !last_pixel;

  downscale_addr_gen #(
    .SRC_W  (SRC_W),
    .SRC_H  (SRC_H),
    .DST_W  (DST_W),
    .DST_H  (DST_H),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (addr_clear),
    .advance    (addr_advance),
    .rd_sel     (rd_sel),
    .mem_addr   (rd_addr),
    .last_pixel (last_pixel)
  );

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic [PIX_W-1:0] sample;
    assign sample = mem_rd_dat[gi*PIX_W +: PIX_W];
`ifdef DOWNSCALE_BOX_EN
    localparam logic [PIX_W+1:0] ROUND = 2;
    logic [PIX_W+1:0] acc_reg, sum;

    // The fourth sample is still on the bus during S_WAIT, so it joins the sum here.
    assign sum = acc_reg + {2'b00, sample} + ROUND;
    assign result[gi*PIX_W +: PIX_W] = is_box ? sum[PIX_W+1:2] : sample;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     acc_reg <= '0;
      else if (state_reg != S_FETCH)  acc_reg <= '0;
      else if (rd_pending_reg)        acc_reg <= acc_reg + {2'b00, sample};
    end
`else
    assign result[gi*PIX_W +: PIX_W] = sample;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef DOWNSCALE_BOX_EN
      mode_reg   <= MODE_NEAREST;
      rd_cnt_reg <= '0;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start_req) begin
            state_reg  <= S_FETCH;
            busy       <= 1'b1;
`ifdef DOWNSCALE_BOX_EN
            mode_reg   <= mode_t'(mode);
            rd_cnt_reg <= '0;
`endif
          end
        end
        S_FETCH: begin
`ifdef DOWNSCALE_BOX_EN
          rd_cnt_reg <= rd_cnt_reg + 2'd1;
`endif
          if (last_rd) state_reg <= S_WAIT;
        end
        S_WAIT: begin
          out_data  <= result;
          out_last  <= last_pixel;
          out_valid <= 1'b1;
          state_reg <= S_EMIT;
        end
        S_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (last_pixel) begin
              state_reg <= S_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              state_reg  <= S_FETCH;
`ifdef DOWNSCALE_BOX_EN
              rd_cnt_reg <= '0;
`endif
            end
          end
        end
        S_DONE: begin
          if (!start_req) begin
            state_reg <= S_IDLE;
            done      <= 1'b0;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_downscale_stream.sv
// Directed bench: three downscaler instances (4x4->2x2, 4x4->4x4, 3-channel 32x32->16x16)
// each backed by a behavioural sync-read memory whose contents are a function of address.
module tb_image_downscale_stream;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 4x4 -> 2x2, mem[i] = i
  logic       start_a, mode_a, rd_en_a, valid_a, ready_a, last_a, busy_a, done_a;
  logic [3:0] addr_a;
  logic [7:0] rd_dat_a, data_a;

  image_downscale_stream #(.PIX_W(8), .CH(1), .SRC_W(4), .SRC_H(4), .DST_W(2), .DST_H(2), .ADDR_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_req(start_a), .mode(mode_a),
    .mem_rd_en(rd_en_a), .mem_addr(addr_a), .mem_rd_dat(rd_dat_a),
    .out_valid(valid_a), .out_ready(ready_a), .out_data(data_a), .out_last(last_a),
    .busy(busy_a), .done(done_a));

  always @(posedge clk) if (rd_en_a) rd_dat_a <= 8'(addr_a);

  // Instance C: 4x4 -> 4x4, mem[i] = i*16
  logic       start_c, mode_c, rd_en_c, valid_c, ready_c, last_c, busy_c, done_c;
  logic [7:0] addr_c, rd_dat_c, data_c;

  image_downscale_stream #(.PIX_W(8), .CH(1), .SRC_W(4), .SRC_H(4), .DST_W(4), .DST_H(4), .ADDR_W(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .start_req(start_c), .mode(mode_c),
    .mem_rd_en(rd_en_c), .mem_addr(addr_c), .mem_rd_dat(rd_dat_c),
    .out_valid(valid_c), .out_ready(ready_c), .out_data(data_c), .out_last(last_c),
    .busy(busy_c), .done(done_c));

  always @(posedge clk) if (rd_en_c) rd_dat_c <= 8'(32'(addr_c) * 16);

  // Instance B: 3 channels, 32x32 -> 16x16, mem word = {i+2, i+1, i}
  logic        start_b, mode_b, rd_en_b, valid_b, ready_b, last_b, busy_b, done_b;
  logic [15:0] addr_b;
  logic [23:0] rd_dat_b, data_b;

  image_downscale_stream #(.PIX_W(8), .CH(3), .SRC_W(32), .SRC_H(32), .DST_W(16), .DST_H(16), .ADDR_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_req(start_b), .mode(mode_b),
    .mem_rd_en(rd_en_b), .mem_addr(addr_b), .mem_rd_dat(rd_dat_b),
    .out_valid(valid_b), .out_ready(ready_b), .out_data(data_b), .out_last(last_b),
    .busy(busy_b), .done(done_b));

  always @(posedge clk) if (rd_en_b) rd_dat_b <= {8'(32'(addr_b) + 2), 8'(32'(addr_b) + 1), 8'(addr_b)};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference for instance C: identity for nearest, clamped 2x2 average for box.
  function automatic logic [7:0] ref_c(input int x, input int y, input bit box);
    int x1, y1, s;
    x1 = (x < 3) ? x + 1 : 3;
    y1 = (y < 3) ? y + 1 : 3;
    if (!box) return 8'((y * 4 + x) * 16);
    s = ((y * 4 + x) + (y * 4 + x1) + (y1 * 4 + x) + (y1 * 4 + x1)) * 16 + 2;
    return 8'(s >> 2);
  endfunction

  task automatic frame_a(input logic md, input bit bp, input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3, input int lat, input string tag);
    logic [7:0] exp_q [4];
    int got, cyc;
    exp_q[0] = e0; exp_q[1] = e1; exp_q[2] = e2; exp_q[3] = e3;
    got = 0; cyc = 0;
    @(negedge clk); mode_a = md; start_a = 1'b1; ready_a = !bp;
    while (got < 4 && cyc < 200) begin
      @(negedge clk); cyc++;
      if (valid_a) begin
        if (got == 0) check({tag, " first valid cycle"}, 32'(cyc), 32'(lat));
        check({tag, " data"}, 32'(data_a), 32'(exp_q[got]));
        check({tag, " last"}, 32'(last_a), 32'(got == 3));
        if (bp) begin
          repeat (2) begin
            @(negedge clk); cyc++;
            check({tag, " stall valid"}, 32'(valid_a), 32'd1);
            check({tag, " stall data"}, 32'(data_a), 32'(exp_q[got]));
            check({tag, " stall last"}, 32'(last_a), 32'(got == 3));
            check({tag, " stall no read"}, 32'(rd_en_a), 32'd0);
          end
          ready_a = 1'b1;
          @(negedge clk); cyc++;
          ready_a = 1'b0;
          check({tag, " valid after handshake"}, 32'(valid_a), 32'd0);
        end
        got++;
      end
    end
    check({tag, " pixel count"}, 32'(got), 32'd4);
    if (!bp) @(negedge clk);
    check({tag, " done"}, 32'(done_a), 32'd1);
    check({tag, " busy in done"}, 32'(busy_a), 32'd0);
    start_a = 1'b0;
    @(negedge clk);
    check({tag, " done cleared"}, 32'(done_a), 32'd0);
  endtask

  task automatic frame_c(input bit md, input string tag);
    int got, cyc;
    got = 0; cyc = 0;
    @(negedge clk); mode_c = md; start_c = 1'b1; ready_c = 1'b1;
    while (got < 16 && cyc < 500) begin
      @(negedge clk); cyc++; start_c = 1'b0;
      if (valid_c) begin
        check({tag, " data"}, 32'(data_c), 32'(ref_c(got % 4, got / 4, md)));
        if (md && got == 0)  check({tag, " pixel(0,0)"}, 32'(data_c), 32'd40);
        if (md && got == 15) check({tag, " pixel(3,3) clamp"}, 32'(data_c), 32'd240);
        check({tag, " last"}, 32'(last_c), 32'(got == 15));
        got++;
      end
    end
    check({tag, " pixel count"}, 32'(got), 32'd16);
    @(negedge clk);
    check({tag, " done"}, 32'(done_c), 32'd1);
  endtask

  task automatic frame_b(input int npix, input string tag);
    int got, cyc, a;
    logic [23:0] e;
    got = 0; cyc = 0;
    @(negedge clk); start_b = 1'b1; ready_b = 1'b1;
    while (got < npix && cyc < 2000) begin
      @(negedge clk); cyc++; start_b = 1'b0;
      if (valid_b) begin
        if (got == 0) check({tag, " first valid cycle"}, 32'(cyc), 32'd3);
        a = (got / 16) * 64 + (got % 16) * 2;
        e = {8'(a + 2), 8'(a + 1), 8'(a)};
        check({tag, " data"}, 32'(data_b), 32'(e));
        check({tag, " last"}, 32'(last_b), 32'(got == 255));
        got++;
      end
    end
    check({tag, " pixel count"}, 32'(got), 32'(npix));
    if (npix == 256) begin
      @(negedge clk);
      check({tag, " done"}, 32'(done_b), 32'd1);
      check({tag, " busy in done"}, 32'(busy_b), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0; mode_a = 1'b0; ready_a = 1'b0;
    start_b = 1'b0; mode_b = 1'b0; ready_b = 1'b0;
    start_c = 1'b0; mode_c = 1'b0; ready_c = 1'b0;
    repeat (3) @(negedge clk);
    check("reset out_valid", 32'(valid_a), 32'd0);
    check("reset out_data", 32'(data_a), 32'd0);
    check("reset out_last", 32'(last_a), 32'd0);
    check("reset busy", 32'(busy_a), 32'd0);
    check("reset done", 32'(done_a), 32'd0);
    check("reset mem_rd_en", 32'(rd_en_a), 32'd0);
    check("reset mem_addr", 32'(addr_a), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle without start", 32'(busy_a), 32'd0);

    frame_a(1'b0, 1'b0, 8'd0, 8'd2, 8'd8, 8'd10, 3, "nearest 4x4->2x2");
    frame_a(1'b0, 1'b1, 8'd0, 8'd2, 8'd8, 8'd10, 3, "backpressure");
`ifdef DOWNSCALE_BOX_EN
    frame_a(1'b1, 1'b0, 8'd3, 8'd5, 8'd11, 8'd13, 6, "box 4x4->2x2");
    frame_c(1'b1, "box 4x4->4x4");
`else
    frame_a(1'b1, 1'b0, 8'd0, 8'd2, 8'd8, 8'd10, 3, "mode ignored");
`endif
    frame_c(1'b0, "identity 4x4->4x4");

    frame_b(256, "rgb 32x32->16x16");
    @(negedge clk);
    check("rgb done cleared", 32'(done_b), 32'd0);

    frame_b(5, "rgb partial");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort out_valid", 32'(valid_b), 32'd0);
    check("abort out_data", 32'(data_b), 32'd0);
    check("abort out_last", 32'(last_b), 32'd0);
    check("abort busy", 32'(busy_b), 32'd0);
    check("abort done", 32'(done_b), 32'd0);
    check("abort mem_rd_en", 32'(rd_en_b), 32'd0);
    check("abort mem_addr", 32'(addr_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    frame_b(1, "restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
